// File: rtl/weight_bank_loader_pkg.sv
// Shared defaults and FSM state type for the weight bank loader.
package weight_loader_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ADDR  = 8;
  localparam int DEF_NUM   = 32;
  localparam int BANK_W    = $clog2(DEF_NUM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/weight_bank_loader_bank.sv
// One weight bank: synchronous write port, asynchronous (distributed RAM) read port.
module weight_bank
  import weight_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR  = DEF_ADDR
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ADDR-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [0:(1<<ADDR)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address read during a write returns the pre-edge contents.
  assign rdata = mem[raddr];

endmodule

// File: rtl/weight_bank_loader.sv
// Run-time reloadable weight store: streams words into NUM banks address-major
// and presents every bank at one shared combinational read address.
module weight_bank_loader
  import weight_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR  = DEF_ADDR,
  parameter int NUM   = DEF_NUM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  input  logic [ADDR-1:0]  address,
  output logic [WIDTH-1:0] rom_out [0:NUM-1],
  output state_t           state
);

  localparam int BW = (NUM > 1) ? $clog2(NUM) : 1;

  // Handshake: a word transfers on a rising edge where in_valid and in_ready
  // are both 1; in_ready depends only on state, never on in_valid.
  state_t          next_state;
  logic [BW-1:0]   bank_cnt;
  logic [ADDR-1:0] addr_cnt;
  logic            fire;
  logic            last_bank;
  logic            last_addr;

  assign fire      = in_valid && in_ready;
  assign last_bank = (bank_cnt == BW'(NUM - 1));
  assign last_addr = (addr_cnt == {ADDR{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (fire && last_bank && last_addr) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (state != LOAD && start) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (fire) begin
      if (last_bank) begin
        bank_cnt <= '0;
        addr_cnt <= addr_cnt + 1'b1;
      end else begin
        bank_cnt <= bank_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM; k++) begin : g_bank
    logic we;
    assign we = fire && (bank_cnt == BW'(k));

    weight_bank #(
      .WIDTH (WIDTH),
      .ADDR  (ADDR)
    ) u_bank (
      .clk   (clk),
      .we    (we),
      .waddr (addr_cnt),
      .wdata (in_data),
      .raddr (address),
      .rdata (rom_out[k])
    );
  end

endmodule
